wishbone_master_adapter_cpu: RTL and testbench
==============================================

// Module: wishbone_master_adapter_cpu
// PURPOSE
//  Wishbone classic-cycle master: turns a simple CPU-side load/store request into a single
//  Wishbone read/write cycle. Sits between the RV32I core's data port and the NoC/Wishbone
//  fabric; drives peripheral slaves such as wb_timer_top and the RAM wrapper. One outstanding
//  transfer, no bursts. Bus timeout converts a hung slave into an error response.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max cycles in BUS awaiting ack/err before abort; 0 = timeout disabled
//  CNT_W           9    width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk_i        in   1   system clock, rising edge
//  rst_n_i      in   1   asynchronous active-low reset
//  req_i        in   1   CPU request strobe; sampled only in IDLE
//  we_i         in   1   1 = store, 0 = load
//  addr_i       in   32  byte address
//  wdata_i      in   32  store data
//  be_i         in   4   byte enables
//  busy_o       out  1   high while a transfer is in flight (state != IDLE)
//  done_o       out  1   one-cycle pulse: transfer finished (ok or error)
//  err_o        out  1   valid with done_o: 1 = wb_err_i or timeout
//  rdata_o      out  32  load data, valid with done_o (held until next load completes)
//  wb_adr_o     out  32  Wishbone address, {addr[31:2],2'b00}
//  wb_dat_o     out  32  Wishbone write data
//  wb_dat_i     in   32  Wishbone read data
//  wb_sel_o     out  4   Wishbone byte select
//  wb_we_o      out  1   Wishbone write enable
//  wb_cyc_o     out  1   Wishbone cycle
//  wb_stb_o     out  1   Wishbone strobe
//  wb_ack_i     in   1   slave acknowledge
//  wb_err_i     in   1   slave error
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): state=IDLE; every output 0 (wb_cyc_o/wb_stb_o drop
//    immediately, mid-cycle included); timeout counter 0. No done_o for an aborted transfer.
//  - All outputs registered. FSM states IDLE, BUS, RESP.
//  - IDLE: req_i=1 at edge N -> latch addr/wdata/be/we into wb_*_o; wb_cyc_o=wb_stb_o=1
//    and busy_o=1 from cycle N+1; state->BUS; counter cleared. req_i=0 -> stay.
//  - BUS: wb_adr/dat/sel/we stable, cyc=stb=1 until termination. Counter +1 per cycle.
//    Termination at edge M: wb_err_i=1 (priority over ack if both), or wb_ack_i=1, or
//    counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0). At edge M: cyc=stb=0, state->RESP;
//    on ack with we=0, rdata_o<=wb_dat_i; err_o<=err|timeout.
//  - RESP (cycle M+1): done_o=1 exactly one cycle, busy_o=1; next edge -> IDLE, busy_o=0.
//  - Latency: req edge N, single-cycle-ack slave acking at first BUS edge (N+1) -> done_o
//    in cycle N+2; new request accepted earliest at edge N+3.
//  - req_i while busy_o=1 ignored (not queued); CPU must hold req_i until accepted.
//  - Write cycles leave rdata_o unchanged; error/timeout loads leave rdata_o unchanged.
//  - Stray wb_ack_i/wb_err_i in IDLE or RESP ignored.
//  - Timeout: cyc/stb high exactly TIMEOUT_CYCLES cycles, then done_o with err_o=1.
// TESTING
//  1 Load addr_i=0x1000_0004, be=4'hF; slave acks 1 cycle after stb with 0xDEAD_BEEF ->
//    wb_adr_o=0x1000_0004, we=0; done_o 1 cycle, err_o=0, rdata_o=0xDEAD_BEEF.
//  2 Store addr_i=0x1000_0007, wdata=0x1234_5678, be=4'b0010 -> wb_adr_o=0x1000_0004,
//    wb_sel_o=4'b0010, wb_we_o=1, fields stable until ack; rdata_o unchanged.
//  3 Slave never responds, TIMEOUT_CYCLES=8 -> cyc/stb high 8 cycles, then done_o=1,
//    err_o=1, busy_o falls next cycle.
//  4 ack and err asserted same cycle -> err_o=1, rdata_o not updated.
//  5 rst_n_i pulled low 2 cycles into BUS -> cyc/stb/busy_o 0 immediately, no done_o;
//    after release, new load completes normally.
//  6 Back-to-back: req_i held high across 3 loads to wb_timer_top -> each accepted only in
//    IDLE, exactly 3 done_o pulses, cyc low >=1 cycle between transfers.

Source files
------------

// File: rtl/wishbone_master_adapter_cpu_if.sv
// Wishbone classic-cycle bus bundle between the CPU adapter (master) and a slave.
interface wishbone_master_adapter_cpu_if;
  logic [31:0] adr;    // word-aligned address
  logic [31:0] dat_w;  // master -> slave write data
  logic [31:0] dat_r;  // slave -> master read data
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wishbone_master_adapter_cpu.sv
// CPU load/store request to single Wishbone classic read/write cycle.
// One transfer in flight; a slave that never terminates is aborted after
// TIMEOUT_CYCLES bus cycles and reported as an error.
module wishbone_master_adapter_cpu #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // CPU side
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  // Wishbone side
  wishbone_master_adapter_cpu_if.master wb
);

  localparam bit              TimeoutEn = (TIMEOUT_CYCLES != 0);
  // Last counter value before abort; unused when the timeout is disabled.
  localparam logic [CNT_W-1:0] CntMax   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        bus_err;
  logic        bus_ack;
  logic        timeout_hit;

  // Termination sources while in BUS; err wins over ack, timeout only if neither.
  always_comb begin
    bus_err     = wb.err;
    bus_ack     = wb.ack & ~wb.err;
    timeout_hit = TimeoutEn && (cnt_q == CntMax) && !wb.ack && !wb.err;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          adr_d   = {addr_i[31:2], 2'b00};
          dat_d   = wdata_i;
          sel_d   = be_i;
          we_d    = we_i;
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = StBus;
        end
      end

      StBus: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_err || bus_ack || timeout_hit) begin
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = bus_err | timeout_hit;
          state_d = StResp;
          if (bus_ack && !we_q) begin
            rdata_d = wb.dat_r;
          end
        end
      end

      StResp: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Drive ports straight from registers.
  always_comb begin
    wb.adr   = adr_q;
    wb.dat_w = dat_q;
    wb.sel   = sel_q;
    wb.we    = we_q;
    wb.cyc   = cyc_q;
    wb.stb   = cyc_q;
    busy_o   = busy_q;
    done_o   = done_q;
    err_o    = err_q;
    rdata_o  = rdata_q;
  end

endmodule

// File: tb/tb_wishbone_master_adapter_cpu.sv
// Randomized bench for the Wishbone master adapter with a transaction-level model.
module tb_wishbone_master_adapter_cpu;

  localparam int unsigned T = 8;
  localparam int KAck  = 0;
  localparam int KErr  = 1;
  localparam int KBoth = 2;
  localparam int KNone = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        busy, done, err;
  logic [31:0] rdata;

  logic        man_ack, man_err, auto_mode;
  logic [31:0] man_dat;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  wishbone_master_adapter_cpu_if bus ();

  // Auto mode: single-cycle-ack slave returning a fixed word.
  assign bus.ack   = auto_mode ? bus.cyc : man_ack;
  assign bus.err   = auto_mode ? 1'b0 : man_err;
  assign bus.dat_r = auto_mode ? 32'h7A00_0000 : man_dat;

  wishbone_master_adapter_cpu #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (4)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .be_i   (be),
    .busy_o (busy),
    .done_o (done),
    .err_o  (err),
    .rdata_o(rdata),
    .wb     (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One CPU transfer; slave answers with 'kind' after 'delay' BUS cycles
  // (KNone: no answer, adapter must abort after T cycles).
  task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input logic [3:0] t_be, input int kind, input int delay,
                         input logic [31:0] t_rdat, input string tag);
    int stop;
    stop = (kind == KNone) ? int'(T) - 1 : delay;
    @(negedge clk);
    man_ack = 1'b0; man_err = 1'b0;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
    @(negedge clk);
    // Scramble CPU inputs: bus fields must come from the latched copy.
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
    for (int k = 0; k <= stop; k++) begin
      check_eq({tag, "/cyc"}, 32'(bus.cyc), 32'd1);
      check_eq({tag, "/stb"}, 32'(bus.stb), 32'd1);
      check_eq({tag, "/busy"}, 32'(busy), 32'd1);
      check_eq({tag, "/done_early"}, 32'(done), 32'd0);
      check_eq({tag, "/adr"}, bus.adr, {t_addr[31:2], 2'b00});
      check_eq({tag, "/sel"}, 32'(bus.sel), 32'(t_be));
      check_eq({tag, "/we"}, 32'(bus.we), 32'(t_we));
      if (t_we) check_eq({tag, "/dat_w"}, bus.dat_w, t_wdata);
      if (k == stop && kind != KNone) begin
        man_ack = (kind == KAck) || (kind == KBoth);
        man_err = (kind == KErr) || (kind == KBoth);
        man_dat = t_rdat;
      end
      @(negedge clk);
      man_ack = 1'b0; man_err = 1'b0;
    end
    if (kind == KAck && !t_we) exp_rdata = t_rdat;
    check_eq({tag, "/done"}, 32'(done), 32'd1);
    check_eq({tag, "/err"}, 32'(err), (kind == KAck) ? 32'd0 : 32'd1);
    check_eq({tag, "/rdata"}, rdata, exp_rdata);
    check_eq({tag, "/cyc_resp"}, 32'(bus.cyc), 32'd0);
    check_eq({tag, "/busy_resp"}, 32'(busy), 32'd1);
    // Stray responses in RESP must be ignored.
    if ($urandom_range(0, 1) == 1) begin
      man_ack = 1'b1; man_err = 1'($urandom); man_dat = $urandom;
    end
    @(negedge clk);
    man_ack = 1'b0; man_err = 1'b0;
    check_eq({tag, "/done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "/busy_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "/cyc_idle"}, 32'(bus.cyc), 32'd0);
    check_eq({tag, "/rdata_hold"}, rdata, exp_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones, rises;
    logic prev_cyc;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    man_ack = 1'b0; man_err = 1'b0; man_dat = '0; auto_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst/cyc", 32'(bus.cyc), 32'd0);
    check_eq("rst/stb", 32'(bus.stb), 32'd0);
    check_eq("rst/busy", 32'(busy), 32'd0);
    check_eq("rst/done", 32'(done), 32'd0);
    check_eq("rst/err", 32'(err), 32'd0);
    check_eq("rst/rdata", rdata, 32'd0);
    check_eq("rst/adr", bus.adr, 32'd0);
    rst_n = 1'b1;

    run_txn(1'b0, 32'h1000_0004, 32'h0, 4'hF, KAck, 0, 32'hDEAD_BEEF, "t1_load");
    run_txn(1'b1, 32'h1000_0007, 32'h1234_5678, 4'b0010, KAck, 2, 32'hFFFF_0000, "t2_store");
    run_txn(1'b0, 32'h1000_0010, 32'h0, 4'hF, KNone, 0, 32'h0, "t3_timeout");
    run_txn(1'b0, 32'h1000_0020, 32'h0, 4'hF, KBoth, 1, 32'h5555_AAAA, "t4_both");

    // Reset two cycles into BUS: bus drops at once, no done.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h1000_0030; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_rdata = '0;
    check_eq("t5/cyc", 32'(bus.cyc), 32'd0);
    check_eq("t5/stb", 32'(bus.stb), 32'd0);
    check_eq("t5/busy", 32'(busy), 32'd0);
    check_eq("t5/done", 32'(done), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("t5/done_rst", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t5/done_after", 32'(done), 32'd0);
    run_txn(1'b0, 32'h1000_0034, 32'h0, 4'hF, KAck, 1, 32'hCAFE_F00D, "t5_load");

    // Back-to-back: req held high, each request accepted only from IDLE.
    @(negedge clk);
    auto_mode = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h2000_0000; be = 4'hF;
    dones = 0; rises = 0; prev_cyc = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 9) req = 1'b0;
      if (done) begin
        dones++;
        check_eq("t6/rdata", rdata, 32'h7A00_0000);
        check_eq("t6/err", 32'(err), 32'd0);
      end
      if (bus.cyc && !prev_cyc) rises++;
      prev_cyc = bus.cyc;
    end
    check_eq("t6/dones", 32'(dones), 32'd3);
    check_eq("t6/cycles", 32'(rises), 32'd3);
    auto_mode = 1'b0;
    exp_rdata = 32'h7A00_0000;

    // Randomized traffic, with occasional stray responses while idle.
    for (int n = 0; n < 40; n++) begin
      int kind;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        man_ack = 1'b1; man_err = 1'($urandom); man_dat = $urandom;
        @(negedge clk);
        man_ack = 1'b0; man_err = 1'b0;
        check_eq("rnd/stray_done", 32'(done), 32'd0);
        check_eq("rnd/stray_rdata", rdata, exp_rdata);
        check_eq("rnd/stray_busy", 32'(busy), 32'd0);
      end
      kind = ($urandom_range(0, 9) < 6) ? KAck : int'($urandom_range(1, 3));
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), kind,
              int'($urandom_range(0, 5)), $urandom, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
